// File: rtl/vec3_length_seq.sv
// Bit-serial Euclidean length |v| of a signed fixed-point 3-vector: squares and sums in one cycle,
// then extracts one root bit per cycle. Define VEC3_LEN_ROUND_EN for round-to-nearest instead of truncation.
module vec3_length_seq #(
    parameter int N    = 32,
    parameter int FRAC = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3*N-1:0] vec,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   length,
    output logic           busy
);

    localparam int CW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SQ   = 2'd1;
    localparam logic [1:0] S_ROOT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Root of a 2N-bit integer with 2*FRAC fraction bits carries FRAC fraction bits.
    if (N < 4 || (N % 2) != 0 || FRAC < 0 || FRAC >= N) begin : g_param_check
        $error("vec3_length_seq: N must be even and >= 4, and 0 <= FRAC < N");
    end

    logic [1:0]     state_q, state_d;
    logic [N-1:0]   x_q, x_d;
    logic [N-1:0]   y_q, y_d;
    logic [N-1:0]   z_q, z_d;
    logic [2*N-1:0] sum_q, sum_d;
    logic [N+1:0]   rem_q, rem_d;
    logic [N-1:0]   root_q, root_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   length_q, length_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q, in_ready_d;

    logic signed [2*N-1:0] sq_x, sq_y, sq_z;
    logic [2*N-1:0]        sum_sq;

    assign sq_x   = $signed(x_q) * $signed(x_q);
    assign sq_y   = $signed(y_q) * $signed(y_q);
    assign sq_z   = $signed(z_q) * $signed(z_q);
    assign sum_sq = $unsigned(sq_x) + $unsigned(sq_y) + $unsigned(sq_z);

    // One digit step: bring down the next two sum bits and try subtracting (4*root + 1).
    // The remainder stays below 2^N until the last step, so its top bits can be dropped on shift.
    logic [N+1:0] rem_shift;
    logic [N+1:0] trial;
    logic         take;
    logic [N+1:0] rem_step;
    logic [N-1:0] root_step;
    logic [N-1:0] root_final;

    assign rem_shift = {rem_q[N-1:0], sum_q[2*N-1:2*N-2]};
    assign trial     = {root_q, 2'b01};
    assign take      = (rem_shift >= trial);
    assign rem_step  = take ? (rem_shift - trial) : rem_shift;
    assign root_step = {root_q[N-2:0], take};

`ifdef VEC3_LEN_ROUND_EN
    // sum - r^2 > r  <=>  sqrt(sum) >= r + 0.5; r+1 cannot wrap since the root stays below 2^N - 1.
    assign root_final = (rem_step > {2'b00, root_step}) ? (root_step + 1'b1) : root_step;
`else
    assign root_final = root_step;
`endif

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        sum_d       = sum_q;
        rem_d       = rem_q;
        root_d      = root_q;
        cnt_d       = cnt_q;
        length_d    = length_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_d     = vec[3*N-1:2*N];
                    y_d     = vec[2*N-1:N];
                    z_d     = vec[N-1:0];
                    state_d = S_SQ;
                end
            end
            S_SQ: begin
                sum_d   = sum_sq;
                rem_d   = '0;
                root_d  = '0;
                cnt_d   = CW'(N - 1);
                state_d = S_ROOT;
            end
            S_ROOT: begin
                sum_d  = sum_q << 2;
                rem_d  = rem_step;
                root_d = root_step;
                if (cnt_q == '0) begin
                    length_d    = root_final;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
        // Registered so it stays low throughout reset and rises on the first edge after release.
        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            sum_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            cnt_q       <= '0;
            length_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            sum_q       <= sum_d;
            rem_q       <= rem_d;
            root_q      <= root_d;
            cnt_q       <= cnt_d;
            length_q    <= length_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign length    = length_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_vec3_length_seq.sv
// Randomised and directed bench for vec3_length_seq (N=32, FRAC=24); reference is a binary-search sqrt.
module tb_vec3_length_seq;

    localparam int N = 32;
    localparam int FRAC = 24;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [3*N-1:0] vec = '0;
    logic           in_ready;
    logic           out_valid;
    logic [N-1:0]   length;
    logic           busy;

    int checks = 0;
    int failures = 0;

    vec3_length_seq #(.N(N), .FRAC(FRAC)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .vec      (vec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .length   (length),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // floor(sqrt(x^2+y^2+z^2)) by binary search over the root, optionally rounded to nearest.
    function automatic logic [31:0] ref_len(input logic [95:0] v);
        longint       x, y, z;
        logic [63:0]  s, r2;
        logic [32:0]  lo, hi, mid;
        logic [127:0] m;
        x = longint'($signed(v[95:64]));
        y = longint'($signed(v[63:32]));
        z = longint'($signed(v[31:0]));
        s = 64'(x * x) + 64'(y * y) + 64'(z * z);
        lo = '0;
        hi = 33'h1_0000_0000;
        while (hi - lo > 1) begin
            mid = (lo + hi) >> 1;
            m = 128'(mid);
            if (m * m <= 128'(s)) lo = mid;
            else hi = mid;
        end
        r2 = 64'(lo) * 64'(lo);
`ifdef VEC3_LEN_ROUND_EN
        if (s - r2 > 64'(lo)) lo = lo + 1;
`endif
        return lo[31:0];
    endfunction

    task automatic run_vec(input string tag, input logic [95:0] v, input logic [31:0] exp, input int bp);
        int waitc = 0;
        int lat = 0;
        while (!in_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_no_stale_valid"}, 64'(out_valid), 64'd0);
        out_ready = (bp == 0);
        in_valid = 1'b1;
        vec = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        vec = {$urandom, $urandom, $urandom};
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_not_ready"}, 64'(in_ready), 64'd0);
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(N + 1));
        check({tag, "_length"}, 64'(length), 64'(exp));
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_length"}, 64'(length), 64'(exp));
            check({tag, "_hold_not_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_retire_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_retire_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_retire_busy"}, 64'(busy), 64'd0);
        out_ready = 1'b0;
        $display("txn %s vec=%h length=%h exp=%h lat=%0d bp=%0d", tag, v, length, exp, lat, bp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [95:0] v;
        logic [31:0] c [3];
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_length", 64'(length), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        check("rel_in_ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("rel_in_ready_after_edge", 64'(in_ready), 64'd1);

        run_vec("t1_345", {32'h0300_0000, 32'h0400_0000, 32'h0}, 32'h0500_0000, 0);
        run_vec("t2_neg345", {32'hFD00_0000, 32'hFC00_0000, 32'h0}, 32'h0500_0000, 1);
        run_vec("t2_zero", 96'h0, 32'h0, 0);
`ifdef VEC3_LEN_ROUND_EN
        run_vec("t3_ones", {32'h0100_0000, 32'h0100_0000, 32'h0100_0000}, 32'h01BB_67AF, 2);
        run_vec("t4_minneg", {32'h8000_0000, 32'h8000_0000, 32'h8000_0000}, 32'd3719550787, 0);
`else
        run_vec("t3_ones", {32'h0100_0000, 32'h0100_0000, 32'h0100_0000}, 32'h01BB_67AE, 2);
        run_vec("t4_minneg", {32'h8000_0000, 32'h8000_0000, 32'h8000_0000}, 32'd3719550786, 0);
`endif
        run_vec("t5_backpressure", {32'h0300_0000, 32'h0400_0000, 32'h0}, 32'h0500_0000, 10);
        v = {32'h7FFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFF};
        run_vec("max_pos", v, ref_len(v), 0);

        // Reset in the middle of the root iterations; the in-flight vector must vanish.
        in_valid = 1'b1;
        vec = {32'h0700_0000, 32'h0100_0000, 32'h0200_0000};
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        check("midrst_length", 64'(length), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        check("midrst_rel_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("midrst_rel_after_edge", 64'(in_ready), 64'd1);
        run_vec("after_rst", {32'hFD00_0000, 32'h0400_0000, 32'h0}, 32'h0500_0000, 0);

        for (int k = 0; k < 30; k++) begin
            for (int j = 0; j < 3; j++) begin
                case ($urandom_range(0, 2))
                    0: c[j] = $urandom;
                    1: c[j] = 32'($signed(12'($urandom_range(0, 4095)))) <<< 20;
                    default: c[j] = 32'($urandom_range(0, 255));
                endcase
            end
            v = {c[0], c[1], c[2]};
            run_vec($sformatf("rnd%0d", k), v, ref_len(v), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
